axis_split_sequencer: RTL and testbench
=======================================

Name: axis_split_sequencer

Overview:
- Controls how one ADC/monitor AXI-Stream is distributed to two downstream consumers (M_AXIS, M_AXIS2) in the RPSPMC signal chain.
- Adds ready/valid backpressure on all three streams, with a 1-deep output register per channel.
- Four routing modes: drop, broadcast, ping-pong and burst-sequenced.
- Config is loaded by strobe and applied only at sample boundaries, so consumers never see a torn burst.

Parameters:
SAXIS_TDATA_WIDTH, 32, input sample width
MAXIS_TDATA_WIDTH, 32, output sample width; input is sign-extended or truncated (LSBs kept) to this width
BURST_WIDTH, 16, width of burst-length config fields and burst counter

Ports:
a_clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
S_AXIS_tdata  in  SAXIS_TDATA_WIDTH  input sample
S_AXIS_tvalid  in  1  input valid
S_AXIS_tready  out  1  input ready
M_AXIS_tdata  out  MAXIS_TDATA_WIDTH  channel A sample
M_AXIS_tvalid  out  1  channel A valid
M_AXIS_tready  in  1  channel A ready
M_AXIS2_tdata  out  MAXIS_TDATA_WIDTH  channel B sample
M_AXIS2_tvalid  out  1  channel B valid
M_AXIS2_tready  in  1  channel B ready
cfg_mode  in  2  0=drop, 1=broadcast, 2=ping-pong, 3=burst
cfg_burst_a  in  BURST_WIDTH  samples per burst to A (mode 3; 0 treated as 1)
cfg_burst_b  in  BURST_WIDTH  samples per burst to B (mode 3; 0 treated as 1)
cfg_load  in  1  one-cycle strobe: capture cfg_* into shadow
count_a  out  32  samples delivered on A (M handshakes), wraps
count_b  out  32  samples delivered on B, wraps
phase  out  1  current target in modes 2/3: 0=A, 1=B

Behaviour:
- Reset is synchronous, active-high, and dominates everything:
  - active mode = 0, shadow cleared, burst counter = 0;
  - phase = 0; both M tvalid = 0; tdata = 0; count_a = count_b = 0;
  - S_AXIS_tready = 0 during reset, then follows the rules below from the next cycle.
- Slot X is "free" when M_X_tvalid=0 or M_X_tready=1 in the same cycle.
- An input transfer occurs when S_AXIS_tvalid & S_AXIS_tready.
  - The selected slot(s) load on that edge; tvalid rises the next cycle (latency 1).
  - tdata is held stable while tvalid=1 and tready=0.
  - tvalid clears after the handshake unless a new sample loads the same edge.
- tready by active mode:
  - mode 0: tready=1; samples discarded; outputs and counters frozen; pending output samples still drain.
  - mode 1: tready = freeA & freeB; both slots load the same sample; no partial delivery.
  - mode 2: tready = free(target); sample goes to target; phase toggles on every transfer.
  - mode 3: tready = free(target); burst counter increments per transfer.
    - On reaching burst_a-1 (phase 0) or burst_b-1 (phase 1): counter clears and phase toggles.
- Config: cfg_load copies cfg_* into the shadow and sets a pending flag. A second cfg_load before apply overwrites the shadow.
- Apply point for the pending shadow:
  - the first cycle with no input transfer, or
  - in mode 3, the transfer completing a burst.
- On apply: active cfg = shadow, phase = 0, burst counter = 0, pending cleared. A transfer in the apply cycle uses the old config.
- Counters: count_a increments on M_AXIS_tvalid & M_AXIS_tready; count_b likewise on channel B. Both wrap 0xFFFFFFFF->0.
- Width rule: signed sign-extension when MAXIS>SAXIS; keep LSBs when narrower.
- Input-handshake timing: tready is combinational from slot state and M tready. No combinational path from S_AXIS_tvalid to S_AXIS_tready.

Test Plan:
- Reset mid-stream (both slots valid, mode 2) -> next cycle tvalid A/B=0, counts=0, phase=0, mode=0. Input 5 after reset is discarded until a cfg_load applies.
- Mode 1, inputs 1,2,3, B tready held low 3 cycles -> S_AXIS_tready=0 while B is stalled. A and B both receive exactly 1,2,3; count_a=count_b=3.
- Mode 2, inputs 10..15, both ready -> A gets 10,12,14; B gets 11,13,15; phase ends 0; latency 1 cycle each.
- Mode 3, burst_a=3, burst_b=2, inputs 0..9 -> A:0,1,2,5,6,7; B:3,4,8,9.
- Mode 3, burst_a=0, burst_b=0 -> each burst behaves as length 1, same as ping-pong.
- cfg_load to mode 2 issued mid-burst in mode 3, continuous input -> switch occurs only after the current burst finishes, then phase=0 and the next sample goes to A. Count wrap: preload count_a near wrap via 2^32 transfers (or force) -> 0xFFFFFFFF+1 reads 0.

Source files
------------

// File: rtl/axis_split_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : axis_split_sequencer
// Description : Splits one AXI-Stream into two output channels using one of
//               four routing modes: drop, broadcast, ping-pong or
//               burst-sequenced. Each output has a 1-deep register slot.
//               Config is double-buffered and applied only at sample
//               boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_split_sequencer #(
    parameter int SAXIS_TDATA_WIDTH = 32,
    parameter int MAXIS_TDATA_WIDTH = 32,
    parameter int BURST_WIDTH       = 16
) (
    input  logic                         a_clk,
    input  logic                         reset,
    input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                         S_AXIS_tvalid,
    output logic                         S_AXIS_tready,
    output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                         M_AXIS_tvalid,
    input  logic                         M_AXIS_tready,
    output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS2_tdata,
    output logic                         M_AXIS2_tvalid,
    input  logic                         M_AXIS2_tready,
    input  logic [1:0]                   cfg_mode,
    input  logic [BURST_WIDTH-1:0]       cfg_burst_a,
    input  logic [BURST_WIDTH-1:0]       cfg_burst_b,
    input  logic                         cfg_load,
    output logic [31:0]                  count_a,
    output logic [31:0]                  count_b,
    output logic                         phase
);

    localparam logic [1:0]             c_mode_drop  = 2'd0;
    localparam logic [1:0]             c_mode_bcast = 2'd1;
    localparam logic [1:0]             c_mode_pp    = 2'd2;
    localparam logic [1:0]             c_mode_burst = 2'd3;
    localparam logic [BURST_WIDTH-1:0] c_bw_one     = {{(BURST_WIDTH-1){1'b0}}, 1'b1};

    // Active and shadow configuration
    logic [1:0]             r_mode;
    logic [BURST_WIDTH-1:0] r_burst_a;
    logic [BURST_WIDTH-1:0] r_burst_b;
    logic [1:0]             r_sh_mode;
    logic [BURST_WIDTH-1:0] r_sh_burst_a;
    logic [BURST_WIDTH-1:0] r_sh_burst_b;
    logic                   r_pending;

    // Sequencing state
    logic                   r_phase;
    logic [BURST_WIDTH-1:0] r_bcnt;

    // Output slots and delivery counters
    logic [MAXIS_TDATA_WIDTH-1:0] r_a_data;
    logic [MAXIS_TDATA_WIDTH-1:0] r_b_data;
    logic                         r_a_valid;
    logic                         r_b_valid;
    logic [31:0]                  r_count_a;
    logic [31:0]                  r_count_b;

    logic [MAXIS_TDATA_WIDTH-1:0] w_sample;
    logic                         w_free_a;
    logic                         w_free_b;
    logic                         w_free_tgt;
    logic                         w_ready;
    logic                         w_xfer;
    logic                         w_load_a;
    logic                         w_load_b;
    logic                         w_toggle;
    logic                         w_burst_end;
    logic                         w_apply;
    logic [BURST_WIDTH-1:0]       w_limit;
    logic [BURST_WIDTH-1:0]       w_limit_m1;

    // Width adaptation: sign-extend when widening, keep LSBs when narrowing
    generate
        if (MAXIS_TDATA_WIDTH > SAXIS_TDATA_WIDTH) begin : g_sext
            assign w_sample = {{(MAXIS_TDATA_WIDTH-SAXIS_TDATA_WIDTH){S_AXIS_tdata[SAXIS_TDATA_WIDTH-1]}},
                               S_AXIS_tdata};
        end else begin : g_trunc
            assign w_sample = S_AXIS_tdata[MAXIS_TDATA_WIDTH-1:0];
        end
    endgenerate

    // Routing decisions: slot availability, input ready, loads and burst end
    always_comb begin
        w_free_a    = !r_a_valid || M_AXIS_tready;
        w_free_b    = !r_b_valid || M_AXIS2_tready;
        w_free_tgt  = r_phase ? w_free_b : w_free_a;
        w_limit     = r_phase ? r_burst_b : r_burst_a;
        // A programmed length of zero behaves as a burst of one
        w_limit_m1  = (w_limit == '0) ? '0 : (w_limit - c_bw_one);
        w_ready     = 1'b0;
        w_load_a    = 1'b0;
        w_load_b    = 1'b0;
        w_toggle    = 1'b0;
        w_burst_end = 1'b0;

        case (r_mode)
            c_mode_drop:  w_ready = 1'b1;
            c_mode_bcast: w_ready = w_free_a && w_free_b;
            default:      w_ready = w_free_tgt;
        endcase
        if (reset) begin
            w_ready = 1'b0;
        end

        w_xfer = S_AXIS_tvalid && w_ready;

        case (r_mode)
            c_mode_bcast: begin
                w_load_a = w_xfer;
                w_load_b = w_xfer;
            end
            c_mode_pp: begin
                w_load_a = w_xfer && !r_phase;
                w_load_b = w_xfer && r_phase;
                w_toggle = w_xfer;
            end
            c_mode_burst: begin
                w_load_a    = w_xfer && !r_phase;
                w_load_b    = w_xfer && r_phase;
                w_burst_end = w_xfer && (r_bcnt == w_limit_m1);
                w_toggle    = w_burst_end;
            end
            default: ;
        endcase

        // Shadow is taken on an idle cycle or right after a burst completes
        w_apply = r_pending && (!w_xfer || w_burst_end);
    end

    // Channel A slot: load on transfer, release after downstream handshake
    always_ff @(posedge a_clk) begin
        if (reset) begin
            r_a_valid <= 1'b0;
            r_a_data  <= '0;
        end else if (w_load_a) begin
            r_a_valid <= 1'b1;
            r_a_data  <= w_sample;
        end else if (M_AXIS_tready) begin
            r_a_valid <= 1'b0;
        end
    end

    // Channel B slot: load on transfer, release after downstream handshake
    always_ff @(posedge a_clk) begin
        if (reset) begin
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
        end else if (w_load_b) begin
            r_b_valid <= 1'b1;
            r_b_data  <= w_sample;
        end else if (M_AXIS2_tready) begin
            r_b_valid <= 1'b0;
        end
    end

    // Delivered-sample counters, free-running with wrap
    always_ff @(posedge a_clk) begin
        if (reset) begin
            r_count_a <= '0;
            r_count_b <= '0;
        end else begin
            if (r_a_valid && M_AXIS_tready) begin
                r_count_a <= r_count_a + 32'd1;
            end
            if (r_b_valid && M2_ready_hs()) begin
                r_count_b <= r_count_b + 32'd1;
            end
        end
    end

    function automatic logic M2_ready_hs();
        return M_AXIS2_tready;
    endfunction

    // Phase and burst counter; a config apply restarts the sequence at A
    always_ff @(posedge a_clk) begin
        if (reset) begin
            r_phase <= 1'b0;
            r_bcnt  <= '0;
        end else if (w_apply) begin
            r_phase <= 1'b0;
            r_bcnt  <= '0;
        end else begin
            if (w_toggle) begin
                r_phase <= ~r_phase;
            end
            if ((r_mode == c_mode_burst) && w_xfer) begin
                r_bcnt <= w_burst_end ? '0 : (r_bcnt + c_bw_one);
            end
        end
    end

    // Shadow capture and apply; a load in the apply cycle stays pending
    always_ff @(posedge a_clk) begin
        if (reset) begin
            r_mode       <= c_mode_drop;
            r_burst_a    <= '0;
            r_burst_b    <= '0;
            r_sh_mode    <= c_mode_drop;
            r_sh_burst_a <= '0;
            r_sh_burst_b <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (w_apply) begin
                r_mode    <= r_sh_mode;
                r_burst_a <= r_sh_burst_a;
                r_burst_b <= r_sh_burst_b;
                r_pending <= 1'b0;
            end
            if (cfg_load) begin
                r_sh_mode    <= cfg_mode;
                r_sh_burst_a <= cfg_burst_a;
                r_sh_burst_b <= cfg_burst_b;
                r_pending    <= 1'b1;
            end
        end
    end

    assign S_AXIS_tready  = w_ready;
    assign M_AXIS_tdata   = r_a_data;
    assign M_AXIS_tvalid  = r_a_valid;
    assign M_AXIS2_tdata  = r_b_data;
    assign M_AXIS2_tvalid = r_b_valid;
    assign count_a        = r_count_a;
    assign count_b        = r_count_b;
    assign phase          = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_axis_split_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_split_sequencer
// Description : Directed, self-checking bench for axis_split_sequencer.
//               Table of routing scenarios plus hand-written sequences for
//               reset, backpressure, latency, config switching and wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_split_sequencer;

    logic        a_clk;
    logic        reset;
    logic [31:0] S_AXIS_tdata;
    logic        S_AXIS_tvalid;
    logic        S_AXIS_tready;
    logic [31:0] M_AXIS_tdata;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tready;
    logic [31:0] M_AXIS2_tdata;
    logic        M_AXIS2_tvalid;
    logic        M_AXIS2_tready;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_burst_a;
    logic [15:0] cfg_burst_b;
    logic        cfg_load;
    logic [31:0] count_a;
    logic [31:0] count_b;
    logic        phase;

    int errors = 0;
    int checks = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    typedef struct packed {
        logic [1:0]  mode;
        logic [15:0] ba;
        logic [15:0] bb;
        logic [31:0] start;
        logic [7:0]  n;
        logic [15:0] a_mask;   // bit k set: sample start+k goes to A
        logic [15:0] b_mask;   // bit k set: sample start+k goes to B
        logic        exp_phase;
    } scn_t;

    scn_t scn [7];

    axis_split_sequencer #(
        .SAXIS_TDATA_WIDTH(32),
        .MAXIS_TDATA_WIDTH(32),
        .BURST_WIDTH(16)
    ) dut (
        .a_clk(a_clk),
        .reset(reset),
        .S_AXIS_tdata(S_AXIS_tdata),
        .S_AXIS_tvalid(S_AXIS_tvalid),
        .S_AXIS_tready(S_AXIS_tready),
        .M_AXIS_tdata(M_AXIS_tdata),
        .M_AXIS_tvalid(M_AXIS_tvalid),
        .M_AXIS_tready(M_AXIS_tready),
        .M_AXIS2_tdata(M_AXIS2_tdata),
        .M_AXIS2_tvalid(M_AXIS2_tvalid),
        .M_AXIS2_tready(M_AXIS2_tready),
        .cfg_mode(cfg_mode),
        .cfg_burst_a(cfg_burst_a),
        .cfg_burst_b(cfg_burst_b),
        .cfg_load(cfg_load),
        .count_a(count_a),
        .count_b(count_b),
        .phase(phase)
    );

    initial a_clk = 1'b0;
    always #5 a_clk = ~a_clk;

    // Record every downstream handshake, sampled mid-cycle
    always @(negedge a_clk) begin
        if (!reset) begin
            if (M_AXIS_tvalid && M_AXIS_tready)   qa.push_back(M_AXIS_tdata);
            if (M_AXIS2_tvalid && M_AXIS2_tready) qb.push_back(M_AXIS2_tdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_stream(input string name, input logic [31:0] got[$], input logic [31:0] exp[$]);
        chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk($sformatf("%s[%0d]", name, i), got[i], exp[i]);
        end
    endtask

    // Entered and left at posedge+1
    task automatic do_reset();
        reset         = 1'b1;
        S_AXIS_tvalid = 1'b0;
        cfg_load      = 1'b0;
        @(posedge a_clk); #1;
        reset = 1'b0;
    endtask

    task automatic configure(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
        cfg_mode      = m;
        cfg_burst_a   = a;
        cfg_burst_b   = b;
        S_AXIS_tvalid = 1'b0;
        cfg_load      = 1'b1;
        @(posedge a_clk); #1;
        cfg_load = 1'b0;
        @(posedge a_clk); #1;
    endtask

    // Offer one sample and wait (bounded) until it is accepted
    task automatic send(input logic [31:0] v);
        int t;
        t             = 0;
        S_AXIS_tdata  = v;
        S_AXIS_tvalid = 1'b1;
        @(negedge a_clk);
        while (!S_AXIS_tready && t < 200) begin
            t++;
            @(negedge a_clk);
        end
        if (!S_AXIS_tready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got tready=0, expected 1 for sample 0x%08h", v);
        end
        @(posedge a_clk); #1;
    endtask

    task automatic idle_drain();
        S_AXIS_tvalid = 1'b0;
        repeat (3) @(posedge a_clk);
        @(negedge a_clk);
    endtask

    initial begin
        logic [31:0] ea[$];
        logic [31:0] eb[$];

        reset          = 1'b1;
        S_AXIS_tdata   = '0;
        S_AXIS_tvalid  = 1'b0;
        M_AXIS_tready  = 1'b1;
        M_AXIS2_tready = 1'b1;
        cfg_mode       = 2'd0;
        cfg_burst_a    = '0;
        cfg_burst_b    = '0;
        cfg_load       = 1'b0;

        //                mode   ba     bb     start   n     a_mask    b_mask    ph
        scn[0] = '{2'd2, 16'd0, 16'd0, 32'd10, 8'd6,  16'h0015, 16'h002A, 1'b0};
        scn[1] = '{2'd3, 16'd3, 16'd2, 32'd0,  8'd10, 16'h00E7, 16'h0318, 1'b0};
        scn[2] = '{2'd3, 16'd0, 16'd0, 32'd20, 8'd6,  16'h0015, 16'h002A, 1'b0};
        scn[3] = '{2'd1, 16'd0, 16'd0, 32'd1,  8'd3,  16'h0007, 16'h0007, 1'b0};
        scn[4] = '{2'd2, 16'd0, 16'd0, 32'd30, 8'd5,  16'h0015, 16'h000A, 1'b1};
        scn[5] = '{2'd0, 16'd0, 16'd0, 32'd40, 8'd3,  16'h0000, 16'h0000, 1'b0};
        scn[6] = '{2'd3, 16'd1, 16'd3, 32'd50, 8'd6,  16'h0011, 16'h002E, 1'b1};

        // Reset state
        @(posedge a_clk); #1;
        @(negedge a_clk);
        chk("rst_tready_in_reset", 32'(S_AXIS_tready), 32'd0);
        @(posedge a_clk); #1;
        reset = 1'b0;
        @(negedge a_clk);
        chk("rst_tvalid_a", 32'(M_AXIS_tvalid), 32'd0);
        chk("rst_tvalid_b", 32'(M_AXIS2_tvalid), 32'd0);
        chk("rst_tdata_a", M_AXIS_tdata, 32'd0);
        chk("rst_count_a", count_a, 32'd0);
        chk("rst_count_b", count_b, 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_tready_mode0", 32'(S_AXIS_tready), 32'd1);
        @(posedge a_clk); #1;

        // Table-driven routing scenarios, both consumers always ready
        for (int s = 0; s < 7; s++) begin
            do_reset();
            M_AXIS_tready  = 1'b1;
            M_AXIS2_tready = 1'b1;
            configure(scn[s].mode, scn[s].ba, scn[s].bb);
            qa.delete();
            qb.delete();
            ea.delete();
            eb.delete();
            for (int k = 0; k < int'(scn[s].n); k++) begin
                send(scn[s].start + 32'(k));
                if (scn[s].a_mask[k]) ea.push_back(scn[s].start + 32'(k));
                if (scn[s].b_mask[k]) eb.push_back(scn[s].start + 32'(k));
            end
            idle_drain();
            chk_stream($sformatf("scn%0d_A", s), qa, ea);
            chk_stream($sformatf("scn%0d_B", s), qb, eb);
            chk($sformatf("scn%0d_count_a", s), count_a, 32'(ea.size()));
            chk($sformatf("scn%0d_count_b", s), count_b, 32'(eb.size()));
            chk($sformatf("scn%0d_phase", s), 32'(phase), 32'(scn[s].exp_phase));
            @(posedge a_clk); #1;
        end

        // Broadcast with channel B stalled: no partial delivery
        do_reset();
        configure(2'd1, 16'd0, 16'd0);
        qa.delete();
        qb.delete();
        M_AXIS_tready  = 1'b1;
        M_AXIS2_tready = 1'b0;
        S_AXIS_tdata   = 32'd1;
        S_AXIS_tvalid  = 1'b1;
        @(negedge a_clk);
        chk("bc_tready_empty", 32'(S_AXIS_tready), 32'd1);
        @(posedge a_clk); #1;
        S_AXIS_tdata = 32'd2;
        @(negedge a_clk);
        chk("bc_tready_stall1", 32'(S_AXIS_tready), 32'd0);
        chk("bc_b_data_held1", M_AXIS2_tdata, 32'd1);
        @(posedge a_clk); #1;
        @(negedge a_clk);
        chk("bc_tready_stall2", 32'(S_AXIS_tready), 32'd0);
        chk("bc_b_data_held2", M_AXIS2_tdata, 32'd1);
        chk("bc_a_drained", 32'(M_AXIS_tvalid), 32'd0);
        @(posedge a_clk); #1;
        M_AXIS2_tready = 1'b1;
        send(32'd2);
        send(32'd3);
        idle_drain();
        ea = '{32'd1, 32'd2, 32'd3};
        chk_stream("bc_A", qa, ea);
        chk_stream("bc_B", qb, ea);
        chk("bc_count_a", count_a, 32'd3);
        chk("bc_count_b", count_b, 32'd3);
        @(posedge a_clk); #1;

        // Ping-pong latency: valid rises exactly one cycle after transfer
        do_reset();
        configure(2'd2, 16'd0, 16'd0);
        S_AXIS_tdata  = 32'd77;
        S_AXIS_tvalid = 1'b1;
        @(negedge a_clk);
        chk("lat_valid_before", 32'(M_AXIS_tvalid), 32'd0);
        @(posedge a_clk); #1;
        S_AXIS_tvalid = 1'b0;
        @(negedge a_clk);
        chk("lat_valid_after", 32'(M_AXIS_tvalid), 32'd1);
        chk("lat_data_after", M_AXIS_tdata, 32'd77);
        chk("lat_phase", 32'(phase), 32'd1);
        @(negedge a_clk);
        chk("lat_valid_cleared", 32'(M_AXIS_tvalid), 32'd0);
        @(posedge a_clk); #1;

        // Mid-stream reset with both slots occupied
        do_reset();
        configure(2'd2, 16'd0, 16'd0);
        M_AXIS_tready  = 1'b0;
        M_AXIS2_tready = 1'b0;
        send(32'd100);
        send(32'd101);
        S_AXIS_tvalid = 1'b0;
        @(negedge a_clk);
        chk("mr_both_full", 32'({M_AXIS_tvalid, M_AXIS2_tvalid}), 32'd3);
        @(posedge a_clk); #1;
        reset = 1'b1;
        @(negedge a_clk);
        chk("mr_tready_in_reset", 32'(S_AXIS_tready), 32'd0);
        @(posedge a_clk); #1;
        reset = 1'b0;
        @(negedge a_clk);
        chk("mr_tvalid_a", 32'(M_AXIS_tvalid), 32'd0);
        chk("mr_tvalid_b", 32'(M_AXIS2_tvalid), 32'd0);
        chk("mr_counts", count_a | count_b, 32'd0);
        chk("mr_phase", 32'(phase), 32'd0);
        @(posedge a_clk); #1;
        M_AXIS_tready  = 1'b1;
        M_AXIS2_tready = 1'b1;
        qa.delete();
        qb.delete();
        send(32'd5);
        idle_drain();
        chk("mr_drop_A", 32'(qa.size()), 32'd0);
        chk("mr_drop_B", 32'(qb.size()), 32'd0);
        @(posedge a_clk); #1;

        // Config change mid-burst waits for the burst to complete
        do_reset();
        configure(2'd3, 16'd3, 16'd2);
        qa.delete();
        qb.delete();
        send(32'd0);
        cfg_mode    = 2'd2;
        cfg_burst_a = 16'd7;
        cfg_burst_b = 16'd7;
        cfg_load    = 1'b1;
        send(32'd1);
        cfg_load = 1'b0;
        for (int k = 2; k < 6; k++) send(32'(k));
        idle_drain();
        ea = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd5};
        eb = '{32'd4};
        chk_stream("sw_A", qa, ea);
        chk_stream("sw_B", qb, eb);
        chk("sw_phase", 32'(phase), 32'd1);
        @(posedge a_clk); #1;

        // Counter wrap via preloaded count
        do_reset();
        configure(2'd1, 16'd0, 16'd0);
        force dut.r_count_a = 32'hFFFF_FFFE;
        @(negedge a_clk);
        release dut.r_count_a;
        chk("wrap_preload", count_a, 32'hFFFF_FFFE);
        @(posedge a_clk); #1;
        send(32'd9);
        S_AXIS_tvalid = 1'b0;
        @(negedge a_clk);
        @(negedge a_clk);
        chk("wrap_max", count_a, 32'hFFFF_FFFF);
        @(posedge a_clk); #1;
        send(32'd10);
        idle_drain();
        chk("wrap_zero", count_a, 32'd0);
        chk("wrap_count_b", count_b, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
